tff2_decoder: RTL
=================

# tff2_decoder

Receive-side counterpart of the two-stage toggle encoder. The encoder XOR-accumulates the data bit into an inner toggle register, then XOR-accumulates that register into the line output `q`. This block samples that `q` stream, inverts both accumulation stages to recover the original bits, and deserializes them LSB-first into W-bit words. Words are delivered over a valid/ready port with a one-word holding register and a sticky overflow flag.

## Interface
- `W`, default 8: word width in bits; legal range 2..32.
- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `q_in`  input  1  encoded line from the encoder `q` output, same clock domain, sampled every cycle.
- `frame_start`  input  1  pulse marking that the bit recovered at this edge is bit 0 of a word.
- `out_data`  output  W  assembled word, LSB = first recovered bit.
- `out_valid`  output  1  `out_data` holds an unconsumed word.
- `out_ready`  input  1  consumer accepts `out_data` at an edge where `out_valid` is high.
- `ovf`  output  1  sticky: a completed word was dropped.
- `ovf_clr`  input  1  clears `ovf`.

## Operation
- Differencer state: `q_d` and `t_d`, both reset to 0, matching the encoder reset state.
- Differencer math, each edge: `t = q_in ^ q_d`, `bit = t ^ t_d`, then `q_d <= q_in` and `t_d <= t`.
- The differencer runs every cycle, in every state, independent of framing and backpressure. It must never stall.
- FSM states:
  - IDLE: ignores recovered bits. Goes to SHIFT when `frame_start` is high; that edge's bit is stored as bit 0 and `cnt <= 1`.
  - SHIFT: stores `bit` at index `cnt` and increments `cnt`. When `cnt == W-1`, the word completes and the FSM returns to IDLE.
  - `frame_start` high while in SHIFT restarts the frame. The partial word is discarded, the current bit becomes bit 0, and `cnt <= 1`.
- Word completion:
  - If `out_valid` is 0, or `out_ready` is 1 at the same edge, load `out_data` and set `out_valid`.
  - Otherwise drop the word, keep the old `out_data`, and set `ovf`.
- Pop: `out_valid && out_ready` with no completion at that edge clears `out_valid`. `out_data` holds its last value.
- `ovf_clr` and a set event on the same edge: set wins.
- `cnt` is $clog2(W)+1 bits wide. It never wraps; it is reset to 1 on each frame start.

## Timing
- Reset values: `out_data` = 0, `out_valid` = 0, `ovf` = 0, FSM = IDLE, `cnt` = 0, `q_d` = 0, `t_d` = 0.
- Reset mid-frame clears everything above immediately (asynchronous). Correct decode afterwards requires the encoder to have been reset in the same cycle.
- Bit latency:
  - A data bit the encoder samples at edge e is recovered at decoder edge e+2.
  - `frame_start` must be asserted at edge e+2 for that bit.
- Word latency: `out_valid` rises after the edge that recovers bit W-1, with no extra pipeline stage.
- Back-to-back frames: `frame_start` may be asserted on the edge immediately after completion. Sustained throughput is one word per W cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `tff2_pkg`:
  - `TFF2_W_DEFAULT` = 8.
  - FSM enum `tff2_dec_state_t` {IDLE, SHIFT}.
  - `localparam` for the counter width function.
- Sub-module `tff2_diff` holds the two XOR-differencing stages (`clk`, `rst`, `q_in` -> `bit`). It is reused by any future toggle-code receiver. The top level holds the FSM, shift register, output register and flags.

## Test plan
- Encoder in loop, reset both. Encoder data = 1 for one cycle at edge 1, then 0. Required: `q_in` toggles every cycle from edge 2, and the decoder recovers 1 at edge 3 then 0 on every later edge.
- Encoder sends 0xA5 LSB-first (1,0,1,0,0,1,0,1) at edges 1–8, `frame_start` at edge 3, `out_ready` = 1. Required: `out_valid` = 1 after edge 10 with `out_data` = 0xA5 for exactly one cycle.
- Back-to-back 0x3C then 0xFF, `out_ready` = 1. Required: two valid pulses 8 cycles apart with correct values, `ovf` = 0.
- Send 0x11, hold `out_ready` = 0, send 0x22. Required: `out_data` stays 0x11 and `ovf` = 1. Then `out_ready` = 1 for one cycle, then `ovf_clr`. Required: `out_valid` = 0 and `ovf` = 0.
- `frame_start` re-asserted after 3 bits of a frame, followed by 0x5A. Required: `out_data` = 0x5A with no trace of the partial bits.
- `rst` asserted mid-frame (bit 4 of 8) on encoder and decoder together, then 0x81 sent. Required: all outputs 0 during reset, then `out_data` = 0x81.

Source files
------------

// File: rtl/tff2_pkg.sv
// Shared definitions for the two-stage toggle-code receiver: default word width,
// decoder FSM encoding and the bit-counter width helper.
package tff2_pkg;

  localparam int TFF2_W_DEFAULT = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tff2_dec_state_t;

  // One extra bit so the counter can reach W without wrapping.
  function automatic int tff2_cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/tff2_diff.sv
// Two cascaded XOR differencers that undo the encoder's double toggle accumulation.
// Runs every cycle; the recovered bit is combinational from q_in and the two delay regs.
module tff2_diff (
  input  logic clk,
  input  logic rst,
  input  logic q_in,
  output logic dbit
);

  logic q_d_r;
  logic t_d_r;
  logic t_s;

  assign t_s  = q_in ^ q_d_r;
  assign dbit = t_s ^ t_d_r;

  // Delay registers for both differencing stages, cleared to the encoder reset state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_d_r <= 1'b0;
      t_d_r <= 1'b0;
    end else begin
      q_d_r <= q_in;
      t_d_r <= t_s;
    end
  end

endmodule

// File: rtl/tff2_decoder.sv
// Toggle-code receiver: recovers bits from the encoder line, frames them LSB-first
// into W-bit words and presents them on a valid/ready port with sticky overflow.
module tff2_decoder
  import tff2_pkg::*;
#(
  parameter int W = TFF2_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         q_in,
  input  logic         frame_start,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         ovf,
  input  logic         ovf_clr
);

  localparam int CW = tff2_cnt_width(W);

  logic            dbit_s;
  tff2_dec_state_t state_r;
  tff2_dec_state_t state_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_nxt_s;
  logic [W-1:0]    shift_r;
  logic [W-1:0]    shift_nxt_s;
  logic            complete_s;
  logic            load_s;
  logic            drop_s;
  logic            pop_s;
  logic [W-1:0]    out_data_r;
  logic            out_valid_r;
  logic            ovf_r;

  tff2_diff u_diff (
    .clk  (clk),
    .rst  (rst),
    .q_in (q_in),
    .dbit (dbit_s)
  );

  // Framing FSM: next state, bit counter and shift register contents.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    shift_nxt_s = shift_r;
    complete_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (frame_start) begin
          shift_nxt_s = {{(W-1){1'b0}}, dbit_s};
          cnt_nxt_s   = CW'(1);
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (frame_start) begin
          // Restart drops the partial word; the current bit becomes bit 0.
          shift_nxt_s = {{(W-1){1'b0}}, dbit_s};
          cnt_nxt_s   = CW'(1);
          state_nxt_s = SHIFT;
        end else begin
          for (int i = 0; i < W; i++) begin
            if (cnt_r == CW'(i)) begin
              shift_nxt_s[i] = dbit_s;
            end else begin
              shift_nxt_s[i] = shift_r[i];
            end
          end
          cnt_nxt_s = cnt_r + CW'(1);
          if (cnt_r == CW'(W - 1)) begin
            complete_s  = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = SHIFT;
          end
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CW{1'b0}};
      end
    endcase
  end

  // Output port handshake decisions for this edge.
  always_comb begin
    load_s = 1'b0;
    drop_s = 1'b0;
    pop_s  = 1'b0;
    if (complete_s) begin
      if (!out_valid_r || out_ready) begin
        load_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      pop_s = out_valid_r & out_ready;
    end
  end

  // FSM, counter and shift register state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      shift_r <= {W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      shift_r <= shift_nxt_s;
    end
  end

  // Holding register, valid flag and sticky overflow (a drop beats a clear).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_r  <= {W{1'b0}};
      out_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      if (load_s) begin
        out_data_r <= shift_nxt_s;
      end
      if (load_s) begin
        out_valid_r <= 1'b1;
      end else if (pop_s) begin
        out_valid_r <= 1'b0;
      end
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr) begin
        ovf_r <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign ovf       = ovf_r;

endmodule
